subneg_core: RTL and testbench

- Initiator side of the SUBNEG program/data memory interface: a multi-cycle fetch/execute sequencer for the one-instruction (SUBNEG) computer.
- Each instruction is three consecutive words at PC: A, B, C.
- Executes mem[B] := mem[B] - mem[A]. If the result is negative, PC := C; otherwise PC := PC + 3.
- Drives a single synchronous memory port (ROM/RAM) and reports run/halt status to the testbench/top level.

---
 rtl/subneg_pkg.sv | 23 ++
 rtl/subneg_alu.sv | 14 +
 rtl/subneg_core.sv | 136 +++++++++++++
 tb/tb_subneg_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/subneg_pkg.sv
// Shared types and constants for the SUBNEG fetch/execute sequencer.
// Word width is a module parameter, so instruction storage is sized in the core.
package subneg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FA,
        S_FB,
        S_FC,
        S_LA,
        S_LB,
        S_EXEC,
        S_HALT
    } state_e;

    localparam int INSTR_WORDS      = 3;
    localparam int CYCLES_PER_INSTR = 6;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/subneg_alu.sv
// Combinational SUBNEG datapath: wrapping subtract plus sign of the result.
module subneg_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] diff,
    output logic             neg
);

    assign diff = minuend - subtrahend;
    assign neg  = diff[WIDTH-1];

endmodule

// File: rtl/subneg_core.sv
// Multi-cycle SUBNEG sequencer: fetch A,B,C, load mem[A] and mem[B], write back
// the difference and branch on its sign. One state per cycle, six per instruction.
module subneg_core
    import subneg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] HALT_ADDR = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             halted,
    output logic [WIDTH-1:0] pc,
    output logic [15:0]      instr_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } instr_t;

    state_e           state;
    instr_t           instr;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res;
    logic             res_neg;

    // In EXEC mem_rdata carries mem[B] from the L_B read.
    subneg_alu #(.WIDTH(WIDTH)) u_alu (
        .minuend   (mem_rdata),
        .subtrahend(opa),
        .diff      (res),
        .neg       (res_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            instr     <= '0;
            opa       <= '0;
            pc        <= RESET_PC;
            instr_cnt <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc        <= RESET_PC;
                        instr_cnt <= '0;
                        busy      <= 1'b1;
                        halted    <= 1'b0;
                        state     <= S_FA;
                    end
                end
                S_FA: state <= S_FB;
                S_FB: begin
                    instr.a <= mem_rdata;
                    state   <= S_FC;
                end
                S_FC: begin
                    instr.b <= mem_rdata;
                    state   <= S_LA;
                end
                S_LA: begin
                    instr.c <= mem_rdata;
                    state   <= S_LB;
                end
                S_LB: begin
                    opa   <= mem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    instr_cnt <= sat_inc(instr_cnt);
                    if (res_neg && instr.c == HALT_ADDR) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (res_neg) begin
                        pc    <= instr.c;
                        state <= S_FA;
                    end else begin
                        pc    <= pc + WIDTH'(INSTR_WORDS);
                        state <= S_FA;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus is decoded from state so reset drops the strobes immediately.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_FA: begin
                mem_addr = pc;
                mem_rd   = 1'b1;
            end
            S_FB: begin
                mem_addr = pc + WIDTH'(1);
                mem_rd   = 1'b1;
            end
            S_FC: begin
                mem_addr = pc + WIDTH'(2);
                mem_rd   = 1'b1;
            end
            S_LA: begin
                mem_addr = instr.a;
                mem_rd   = 1'b1;
            end
            S_LB: begin
                mem_addr = instr.b;
                mem_rd   = 1'b1;
            end
            S_EXEC: begin
                mem_addr  = instr.b;
                mem_wr    = 1'b1;
                mem_wdata = res;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_subneg_core.sv
// Bench for subneg_core: instruction-level reference model expanded into expected
// per-cycle bus/status observations, directed programs plus randomized memory images.
module tb_subneg_core;
    import subneg_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic [15:0] instr_cnt;

    subneg_core #(.WIDTH(8), .RESET_PC(8'd0), .HALT_ADDR(8'hFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .halted   (halted),
        .pc       (pc),
        .instr_cnt(instr_cnt)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
        logic [7:0]  pc;
        logic [15:0] cnt;
        logic        busy;
        logic        halted;
    } obs_t;

    logic [7:0] mem [256];
    obs_t       exp_q [$];
    obs_t       cmp_e;
    obs_t       cmp_a;
    int         checks = 0;
    int         passes = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port memory: read data one cycle after mem_rd.
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_a = '{mem_addr, mem_rd, mem_wr, mem_wdata, pc, instr_cnt, busy, halted};
            chk("cycle", 64'(cmp_a), 64'(cmp_e));
        end
    end

    // Execute the program instruction by instruction and expand each into its bus cycles.
    task automatic build(input int ncyc);
        logic [7:0]  m [256];
        logic [7:0]  p, a, b, c, res;
        logic [15:0] n;
        bit          h;
        int          k;
        obs_t        e [6];
        m = mem;
        p = 8'd0;
        n = 16'd0;
        h = 1'b0;
        k = 0;
        while (k < ncyc) begin
            if (h) begin
                exp_q.push_back('{8'h00, 1'b0, 1'b0, 8'h00, p, n, 1'b0, 1'b1});
                k++;
            end else begin
                a   = m[p];
                b   = m[p + 8'd1];
                c   = m[p + 8'd2];
                res = m[b] - m[a];
                e[0] = '{p,         1'b1, 1'b0, 8'h00, p, n, 1'b1, 1'b0};
                e[1] = '{p + 8'd1,  1'b1, 1'b0, 8'h00, p, n, 1'b1, 1'b0};
                e[2] = '{p + 8'd2,  1'b1, 1'b0, 8'h00, p, n, 1'b1, 1'b0};
                e[3] = '{a,         1'b1, 1'b0, 8'h00, p, n, 1'b1, 1'b0};
                e[4] = '{b,         1'b1, 1'b0, 8'h00, p, n, 1'b1, 1'b0};
                e[5] = '{b,         1'b0, 1'b1, res,   p, n, 1'b1, 1'b0};
                for (int j = 0; j < CYCLES_PER_INSTR; j++) begin
                    if (k < ncyc) exp_q.push_back(e[j]);
                    k++;
                end
                m[b] = res;
                if (n != 16'hFFFF) n = n + 16'd1;
                if (res[7]) begin
                    if (c == 8'hFF) h = 1'b1;
                    else p = c;
                end else begin
                    p = p + 8'd3;
                end
            end
        end
    endtask

    // Runs ncyc cycles after start is accepted; a stray start is pulsed while busy.
    task automatic run_prog(input int ncyc, input bit do_rst);
        if (do_rst) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        build(ncyc);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ncyc - 3) @(negedge clk);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();
        #12;
        chk("rst_pc",     64'(pc),        64'd0);
        chk("rst_busy",   64'(busy),      64'd0);
        chk("rst_halted", 64'(halted),    64'd0);
        chk("rst_rd_wr",  64'({mem_rd, mem_wr}), 64'd0);
        chk("rst_cnt",    64'(instr_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fall-through: mem[17] = 10 - 3 = 7
        clear_mem();
        mem[0] = 8'd16; mem[1] = 8'd17; mem[2] = 8'd9;
        mem[16] = 8'd3; mem[17] = 8'd10;
        run_prog(6, 1'b0);
        @(negedge clk); #1;
        chk("ft_pc",   64'(pc),        64'd3);
        chk("ft_cnt",  64'(instr_cnt), 64'd1);
        chk("ft_data", 64'(mem[17]),   64'd7);

        // Reset during the second instruction's EXEC: strobe drops, write is lost
        g = 0;
        while (!mem_wr && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("exec_seen", 64'(g < 20), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_wr",   64'(mem_wr), 64'd0);
        chk("arst_pc",   64'(pc),     64'd0);
        chk("arst_busy", 64'(busy),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("arst_idle", 64'({busy, halted, mem_rd, mem_wr}), 64'd0);
        chk("arst_nowr", 64'(mem[0]), 64'd16);

        // Branch: 10 - 12 = 0xFE, pc := 9
        clear_mem();
        mem[0] = 8'd16; mem[1] = 8'd17; mem[2] = 8'd9;
        mem[16] = 8'd12; mem[17] = 8'd10;
        run_prog(6, 1'b1);
        @(negedge clk); #1;
        chk("br_pc",   64'(pc),      64'd9);
        chk("br_data", 64'(mem[17]), 64'hFE);

        // Halt after two instructions, then restart from HALT
        clear_mem();
        mem[0] = 8'd16; mem[1] = 8'd16; mem[2] = 8'd255;
        mem[3] = 8'd17; mem[4] = 8'd18; mem[5] = 8'd255;
        mem[17] = 8'd1;
        run_prog(20, 1'b1);
        chk("h_halted", 64'(halted),    64'd1);
        chk("h_cnt",    64'(instr_cnt), 64'd2);
        chk("h_data",   64'(mem[18]),   64'hFF);
        chk("h_pc",     64'(pc),        64'd3);
        run_prog(20, 1'b0);
        chk("rs_halted", 64'(halted),    64'd1);
        chk("rs_cnt",    64'(instr_cnt), 64'd2);
        chk("rs_data",   64'(mem[18]),   64'hFE);

        // Branch to 254, instruction straddles the top of memory
        clear_mem();
        mem[0] = 8'd20; mem[1] = 8'd21; mem[2] = 8'd254;
        mem[20] = 8'd5; mem[21] = 8'd1;
        mem[254] = 8'd16; mem[255] = 8'd17;
        mem[16] = 8'd3; mem[17] = 8'd10;
        run_prog(12, 1'b1);
        @(negedge clk); #1;
        chk("wr_pc",  64'(pc),        64'd1);
        chk("wr_cnt", 64'(instr_cnt), 64'd2);
        chk("wr_b0",  64'(mem[21]),   64'hFC);
        chk("wr_b1",  64'(mem[17]),   64'd7);

        // Random memory images, C words biased toward the halt address
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                if (i % 3 == 2 && $urandom_range(3) == 0) mem[i] = 8'hFF;
            end
            run_prog(150, 1'b1);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
